pds_e_sequencer: RTL

// - 6800-style synchronous peripheral cycle sequencer for the SE PDS bus (VIA/SCC accesses via VPA).
// - Generates the free-running E clock (C8M/10) and drives VMA in step with E.
// - Issues the 6800 cycle termination consumed by the CPU bus translation stage (-> DSACK1/AVEC).
// - Sits downstream of PDS VPA decode, upstream of the translator's termination logic.

---
 rtl/pds_e_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pds_e_sequencer.sv
// 6800-style E-clock / VMA cycle sequencer for the SE PDS bus (VPA-decoded VIA/SCC accesses).
// Define E68_TIMEOUT_EN to add the timeout counter and the ERR termination path.
module pds_e_sequencer #(
   parameter int E_PERIOD       = 10,
   parameter int E_HIGH_START   = 6,
   parameter int VMA_COUNT      = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       pdsC8M,
   input  logic       pdsRESETn,
   input  logic       cpuASn,
   input  logic       pdsVPAn,
   output logic       pdsClockE,
   output logic       pdsVMAn,
   output logic       cyc68Ackn,
   output logic       cyc68Errn,
   output logic [3:0] ePhase
);

   localparam logic [3:0] E_LAST  = 4'(E_PERIOD - 1);
   localparam logic [3:0] E_HIGH  = 4'(E_HIGH_START);
   localparam logic [3:0] E_VMA   = 4'(VMA_COUNT);

   if ((VMA_COUNT >= E_HIGH_START) || (E_PERIOD > 16) || (TIMEOUT_CYCLES > 127)
       || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
      $error("pds_e_sequencer: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SYNC = 3'd1,
      ST_VMA_ON    = 3'd2,
      ST_ACK       = 3'd3
`ifdef E68_TIMEOUT_EN
      , ST_ERR     = 3'd4
`endif
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] e_count_q, e_count_d;
   logic       clock_e_q, clock_e_d;
   logic       vma_n_q, vma_n_d;
   logic       ack_n_q, ack_n_d;
   logic       as_meta_q, as_sync_q;
   logic       vpa_meta_q, vpa_sync_q;
   logic       armed_q, armed_d;
   logic       wrap_s;
   logic       vma_edge_s;
   logic       timeout_hit_s;

   // Synchronisers for the asynchronous strobes; idle-high out of reset.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         as_meta_q  <= 1'b1;
         as_sync_q  <= 1'b1;
         vpa_meta_q <= 1'b1;
         vpa_sync_q <= 1'b1;
      end else begin
         as_meta_q  <= cpuASn;
         as_sync_q  <= as_meta_q;
         vpa_meta_q <= pdsVPAn;
         vpa_sync_q <= vpa_meta_q;
      end
   end

   // Free-running E phase counter and E clock next values.
   always_comb begin
      e_count_d = (e_count_q == E_LAST) ? 4'd0 : e_count_q + 4'd1;
      if (e_count_d == E_HIGH) begin
         clock_e_d = 1'b1;
      end else if (e_count_d == 4'd0) begin
         clock_e_d = 1'b0;
      end else begin
         clock_e_d = clock_e_q;
      end
      wrap_s     = (e_count_d == 4'd0);
      vma_edge_s = (e_count_d == E_VMA);
   end

   // E phase counter and E clock registers.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         e_count_q <= 4'd0;
         clock_e_q <= 1'b0;
      end else begin
         e_count_q <= e_count_d;
         clock_e_q <= clock_e_d;
      end
   end

`ifdef E68_TIMEOUT_EN
   localparam logic [6:0] TO_LIMIT = 7'(TIMEOUT_CYCLES);

   logic [6:0] to_count_q, to_count_d, to_inc_s;
   logic       err_n_q, err_n_d;
   logic       in_cycle_s;

   // Saturating timeout counter, cleared whenever no cycle is pending.
   always_comb begin
      in_cycle_s    = (state_q == ST_WAIT_SYNC) || (state_q == ST_VMA_ON);
      to_inc_s      = (to_count_q == 7'h7F) ? to_count_q : to_count_q + 7'd1;
      to_count_d    = in_cycle_s ? to_inc_s : 7'd0;
      timeout_hit_s = in_cycle_s && (to_inc_s >= TO_LIMIT);
   end

   // Timeout counter register.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         to_count_q <= 7'd0;
      end else begin
         to_count_q <= to_count_d;
      end
   end

   // Error strobe follows the ERR state one edge ahead so it is registered.
   always_comb begin
      err_n_d = (state_d == ST_ERR) ? 1'b0 : 1'b1;
   end

   // Error output register.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         err_n_q <= 1'b1;
      end else begin
         err_n_q <= err_n_d;
      end
   end

   assign cyc68Errn = err_n_q;
`else
   assign timeout_hit_s = 1'b0;
   assign cyc68Errn     = 1'b1;
`endif

   // State register; armed_q remembers that AS was seen negated since the last request.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
      end
   end

   // Next-state logic; AS negation aborts from every state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!as_sync_q && !vpa_sync_q && armed_q) begin
               state_d = ST_WAIT_SYNC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_SYNC: begin
            if (as_sync_q || vpa_sync_q) begin
               state_d = ST_IDLE;
`ifdef E68_TIMEOUT_EN
            end else if (timeout_hit_s) begin
               state_d = ST_ERR;
`endif
            end else if (vma_edge_s) begin
               state_d = ST_VMA_ON;
            end else begin
               state_d = ST_WAIT_SYNC;
            end
         end
         ST_VMA_ON: begin
            // Termination on E fall takes precedence over a coincident timeout.
            if (as_sync_q) begin
               state_d = ST_IDLE;
            end else if (wrap_s) begin
               state_d = ST_ACK;
`ifdef E68_TIMEOUT_EN
            end else if (timeout_hit_s) begin
               state_d = ST_ERR;
`endif
            end else begin
               state_d = ST_VMA_ON;
            end
         end
         ST_ACK: begin
            if (as_sync_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACK;
            end
         end
`ifdef E68_TIMEOUT_EN
         ST_ERR: begin
            if (as_sync_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ERR;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if ((state_q == ST_IDLE) && as_sync_q) begin
         armed_d = 1'b1;
      end else if ((state_q == ST_IDLE) && (state_d == ST_WAIT_SYNC)) begin
         armed_d = 1'b0;
      end else begin
         armed_d = armed_q;
      end
   end

   // Output decode from the next state so the bus strobes come straight from flops.
   always_comb begin
      vma_n_d = ((state_d == ST_VMA_ON) || (state_d == ST_ACK)) ? 1'b0 : 1'b1;
      ack_n_d = (state_d == ST_ACK) ? 1'b0 : 1'b1;
   end

   // Bus strobe output registers.
   always_ff @(posedge pdsC8M or negedge pdsRESETn) begin
      if (!pdsRESETn) begin
         vma_n_q <= 1'b1;
         ack_n_q <= 1'b1;
      end else begin
         vma_n_q <= vma_n_d;
         ack_n_q <= ack_n_d;
      end
   end

   assign pdsClockE = clock_e_q;
   assign pdsVMAn   = vma_n_q;
   assign cyc68Ackn = ack_n_q;
   assign ePhase    = e_count_q;

endmodule
